w_schedule_ctrl: RTL and testbench
==================================

// Module: w_schedule_ctrl
// PURPOSE
//  Sequencer for the SHA-256 message-schedule datapath: accepts one 512-bit block per
//  handshake, steps the W index 0..63 (direct load 0..15, sigma expansion 16..63) and
//  paces each word to the compression-round consumer via valid/ready.
//  Sits between the padder/block source and the w-load / w-expand datapath modules.
//  The compression rounds receive one W word per accepted beat.
// PARAMETERS
//  W_LENGTH    64                  number of schedule words per block
//  LOAD_WORDS  16                  words taken directly from the message block
//  IDX_W       $clog2(W_LENGTH)    width of the W index
// PORTS
//  clock          in   1      sole clock, rising edge
//  reset          in   1      synchronous, active-low reset
//  msg_valid      in   1      upstream block available
//  msg_last       in   1      block is final block of message (sampled with msg_valid & msg_ready)
//  msg_ready      out  1      controller can accept a block
//  abort          in   1      synchronous abandon of current block
//  w_ready        in   1      round consumer accepts current W word
//  w_valid        out  1      current W word valid at datapath output
//  load_en        out  1      datapath: copy message word w_index (phase LOAD)
//  expand_en      out  1      datapath: compute W[w_index] from W[i-2,7,15,16] (phase EXPAND)
//  w_index        out  IDX_W  index of word currently presented
//  w_index_complete out 1     high for one cycle after W[63] accepted
//  block_done     out  1      one-cycle pulse, same cycle as w_index_complete
//  block_last     out  1      msg_last of the block in flight, valid while busy and with block_done
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, w_index=0, every output 0 except msg_ready=1.
//  States: IDLE, LOAD, EXPAND, DONE.  beat = w_valid & w_ready.
//  IDLE: msg_ready=1; on msg_valid -> LOAD, w_index<=0, block_last<=msg_last.
//  LOAD: w_valid=1, load_en=1; beat -> w_index+1; beat at index LOAD_WORDS-1 -> EXPAND.
//  EXPAND: w_valid=1, expand_en=1; beat -> w_index+1; beat at index W_LENGTH-1 -> DONE,
//    w_index held at W_LENGTH-1 (no wrap to 0 inside the block).
//  DONE (exactly 1 cycle): w_index_complete=1, block_done=1, w_valid=0, msg_ready=1;
//    msg_valid -> LOAD with w_index<=0 (back-to-back, no idle bubble), else -> IDLE.
//  No beat (w_ready low): w_index, state and enables hold; w_valid stays high.
//  Index increment is on the same edge that completes the beat; latency message-accept
//    to first w_valid = 1 cycle; min block time = 64 beats + 1 DONE cycle = 65 cycles.
//  abort=1 in LOAD/EXPAND/DONE: next state IDLE, w_index<=0, no block_done/w_index_complete;
//    abort wins over a simultaneous beat and over a simultaneous msg_valid in DONE.
//    abort in IDLE is ignored (msg_ready still 1, msg accept still allowed).
//  reset mid-block behaves as abort plus clearing block_last.
//  msg_ready is 0 in LOAD and EXPAND; msg_valid there is ignored (upstream holds).
//  load_en and expand_en are mutually exclusive and both 0 when w_valid=0.
//  Index arithmetic is unsigned IDX_W bits; compare against LOAD_WORDS-1 and W_LENGTH-1 only.
// STRUCTURE
//  Shared package sha256_pkg: state enum (IDLE/LOAD/EXPAND/DONE), W_LENGTH, LOAD_WORDS constants.
//  Single module; optional sub-module w_index_counter (load-zero / increment-on-beat / hold).
//  Controller carries no message data; datapath modules consume load_en/expand_en/w_index.
// TESTING
//  1 reset low 2 cycles -> msg_ready=1, busy=0, w_valid=0, w_index=0.
//  2 one block, w_ready tied 1 -> load_en for idx 0..15, expand_en 16..63; block_done
//    pulses 65 cycles after accept.
//  3 w_ready low for 3 cycles at idx 15 -> index and load_en hold, EXPAND entered only
//    after the beat; same stall at idx 63 delays block_done by 3.
//  4 two blocks, msg_valid held, second with msg_last=1 -> DONE->LOAD direct,
//    w_index 63->0, block_last=1 on second block_done.
//  5 abort with w_ready=1 at idx 40 -> IDLE next cycle, no block_done, w_index=0;
//    new block then runs full 0..63.
//  6 reset low at idx 20 -> all outputs at reset values next cycle, block_last=0.

Source files
------------

// File: rtl/w_schedule_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message-schedule sequencer.
package sha256_pkg;

    localparam int W_LENGTH   = 64;
    localparam int LOAD_WORDS = 16;
    localparam int IDX_W      = $clog2(W_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/w_schedule_ctrl_if.sv
// Handshake bundle between the block source, the schedule controller and the
// round consumer / W datapath.
interface w_schedule_ctrl_if;

    logic                         msg_valid;
    logic                         msg_last;
    logic                         msg_ready;
    logic                         abort;
    logic                         w_ready;
    logic                         w_valid;
    logic                         load_en;
    logic                         expand_en;
    logic [sha256_pkg::IDX_W-1:0] w_index;
    logic                         w_index_complete;
    logic                         block_done;
    logic                         block_last;
    logic                         busy;

    // Controller side
    modport master (
        input  msg_valid, msg_last, abort, w_ready,
        output msg_ready, w_valid, load_en, expand_en, w_index,
               w_index_complete, block_done, block_last, busy
    );

    // Source / consumer side
    modport slave (
        output msg_valid, msg_last, abort, w_ready,
        input  msg_ready, w_valid, load_en, expand_en, w_index,
               w_index_complete, block_done, block_last, busy
    );

endinterface

// File: rtl/w_schedule_ctrl_index_counter.sv
// W index register: clear to zero, increment on request, otherwise hold.
module w_index_counter #(
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_idx;

    // Index register; clear has priority over increment
    always_ff @(posedge clock) begin
        if (!reset || i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/w_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: accepts one block per handshake, walks
// W index 0..63 (load 0..15, expand 16..63) and paces each word to the rounds.
module w_schedule_ctrl #(
    parameter int W_LENGTH   = sha256_pkg::W_LENGTH,
    parameter int LOAD_WORDS = sha256_pkg::LOAD_WORDS,
    parameter int IDX_W      = $clog2(W_LENGTH)
) (
    input  logic             clock,
    input  logic             reset,
    w_schedule_ctrl_if.master bus
);
    import sha256_pkg::*;

    localparam logic [IDX_W-1:0] LAST_LOAD = IDX_W'(LOAD_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_W    = IDX_W'(W_LENGTH - 1);

    sched_state_e     r_state;
    sched_state_e     w_next;
    logic [IDX_W-1:0] w_idx;
    logic             w_idx_clr;
    logic             w_idx_inc;
    logic             w_accept;
    logic             w_beat;
    logic             r_block_last;

    assign w_beat = ((r_state == ST_LOAD) || (r_state == ST_EXPAND)) && bus.w_ready;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and index control; abort outranks beats and new blocks
    always_comb begin
        w_next    = r_state;
        w_idx_clr = 1'b0;
        w_idx_inc = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.msg_valid) begin
                    w_next    = ST_LOAD;
                    w_idx_clr = 1'b1;
                    w_accept  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    w_next    = ST_IDLE;
                    w_idx_clr = 1'b1;
                end else if (w_beat) begin
                    w_idx_inc = 1'b1;
                    if (w_idx == LAST_LOAD) begin
                        w_next = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                if (bus.abort) begin
                    w_next    = ST_IDLE;
                    w_idx_clr = 1'b1;
                end else if (w_beat) begin
                    // Last word: hold index at W_LENGTH-1 rather than wrapping
                    if (w_idx == LAST_W) begin
                        w_next = ST_DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    w_next    = ST_IDLE;
                    w_idx_clr = 1'b1;
                end else if (bus.msg_valid) begin
                    w_next    = ST_LOAD;
                    w_idx_clr = 1'b1;
                    w_accept  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next    = ST_IDLE;
                w_idx_clr = 1'b1;
            end
        endcase
    end

    // Capture the final-block flag of each accepted block
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_block_last <= 1'b0;
        end else if (w_accept) begin
            r_block_last <= bus.msg_last;
        end
    end

    w_index_counter #(
        .IDX_W (IDX_W)
    ) u_index (
        .clock (clock),
        .reset (reset),
        .i_clr (w_idx_clr),
        .i_inc (w_idx_inc),
        .o_idx (w_idx)
    );

    // Moore outputs decoded from the current state
    always_comb begin
        bus.msg_ready        = 1'b0;
        bus.w_valid          = 1'b0;
        bus.load_en          = 1'b0;
        bus.expand_en        = 1'b0;
        bus.w_index_complete = 1'b0;
        bus.block_done       = 1'b0;
        bus.busy             = (r_state != ST_IDLE);
        bus.w_index          = w_idx;
        bus.block_last       = r_block_last;
        case (r_state)
            ST_IDLE: begin
                bus.msg_ready = 1'b1;
            end
            ST_LOAD: begin
                bus.w_valid = 1'b1;
                bus.load_en = 1'b1;
            end
            ST_EXPAND: begin
                bus.w_valid   = 1'b1;
                bus.expand_en = 1'b1;
            end
            ST_DONE: begin
                bus.msg_ready        = 1'b1;
                bus.w_index_complete = 1'b1;
                bus.block_done       = 1'b1;
            end
            default: begin
                bus.msg_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_w_schedule_ctrl.sv
// Directed bench for the SHA-256 message-schedule sequencer.
module tb_w_schedule_ctrl;

    localparam int IDX_W = sha256_pkg::IDX_W;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   t0;

    w_schedule_ctrl_if bus();

    w_schedule_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [IDX_W-1:0] obs, input logic [IDX_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_msg_ready"}, bus.msg_ready, 1'b1);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_w_valid"}, bus.w_valid, 1'b0);
        chk1({tag, "_load_en"}, bus.load_en, 1'b0);
        chk1({tag, "_expand_en"}, bus.expand_en, 1'b0);
        chk1({tag, "_done"}, bus.block_done, 1'b0);
        chk1({tag, "_complete"}, bus.w_index_complete, 1'b0);
        chkn({tag, "_w_index"}, bus.w_index, '0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        reset         = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.abort     = 1'b0;
        bus.w_ready   = 1'b0;

        // 1: reset held two cycles
        tick();
        tick();
        chk_idle("rst");
        chk1("rst_block_last", bus.block_last, 1'b0);
        reset = 1'b1;

        // 2: single block, consumer always ready
        bus.w_ready   = 1'b1;
        bus.msg_valid = 1'b1;
        chk1("s2_ready_idle", bus.msg_ready, 1'b1);
        tick();
        t0 = cyc;
        bus.msg_valid = 0;
        for (int i = 0; i < 64; i++) begin
            chkn("s2_idx", bus.w_index, IDX_W'(i));
            chk1("s2_load", bus.load_en, i < 16);
            chk1("s2_expand", bus.expand_en, i >= 16);
            chk1("s2_valid", bus.w_valid, 1'b1);
            chk1("s2_no_ready", bus.msg_ready, 1'b0);
            chk1("s2_no_done", bus.block_done, 1'b0);
            tick();
        end
        chk1("s2_done", bus.block_done, 1'b1);
        chk1("s2_complete", bus.w_index_complete, 1'b1);
        chk1("s2_valid_low", bus.w_valid, 1'b0);
        chk1("s2_done_ready", bus.msg_ready, 1'b1);
        chkn("s2_idx_hold", bus.w_index, IDX_W'(63));
        chki("s2_latency", cyc - t0 + 1, 65);
        tick();
        chk1("s2_idle_busy", bus.busy, 1'b0);
        chk1("s2_idle_done", bus.block_done, 1'b0);

        // 3: stalls at idx 15 and idx 63
        bus.msg_valid = 1'b1;
        tick();
        t0 = cyc;
        bus.msg_valid = 1'b0;
        repeat (15) tick();
        bus.w_ready = 1'b0;
        repeat (3) begin
            chkn("s3_stall15_idx", bus.w_index, IDX_W'(15));
            chk1("s3_stall15_load", bus.load_en, 1'b1);
            chk1("s3_stall15_expand", bus.expand_en, 1'b0);
            chk1("s3_stall15_valid", bus.w_valid, 1'b1);
            tick();
        end
        bus.w_ready = 1'b1;
        chkn("s3_beat15_idx", bus.w_index, IDX_W'(15));
        tick();
        chkn("s3_idx16", bus.w_index, IDX_W'(16));
        chk1("s3_expand16", bus.expand_en, 1'b1);
        chk1("s3_load16", bus.load_en, 1'b0);
        repeat (47) tick();
        chkn("s3_idx63", bus.w_index, IDX_W'(63));
        bus.w_ready = 1'b0;
        repeat (3) begin
            chkn("s3_stall63_idx", bus.w_index, IDX_W'(63));
            chk1("s3_stall63_expand", bus.expand_en, 1'b1);
            chk1("s3_stall63_no_done", bus.block_done, 1'b0);
            tick();
        end
        bus.w_ready = 1'b1;
        tick();
        chk1("s3_done", bus.block_done, 1'b1);
        chki("s3_latency", cyc - t0 + 1, 71);
        tick();
        chk1("s3_idle_busy", bus.busy, 1'b0);

        // 4: back-to-back blocks, msg_valid held, second is final
        bus.msg_valid = 1'b1;
        bus.msg_last  = 1'b0;
        tick();
        t0 = cyc;
        bus.msg_last = 1'b1;
        chk1("s4_ready_busy", bus.msg_ready, 1'b0);
        chk1("s4_last_first", bus.block_last, 1'b0);
        repeat (63) tick();
        chkn("s4_idx63", bus.w_index, IDX_W'(63));
        chk1("s4_ready63", bus.msg_ready, 1'b0);
        tick();
        chk1("s4_done1", bus.block_done, 1'b1);
        chk1("s4_done1_last", bus.block_last, 1'b0);
        chk1("s4_done1_ready", bus.msg_ready, 1'b1);
        chkn("s4_done1_idx", bus.w_index, IDX_W'(63));
        tick();
        chkn("s4_b2_idx0", bus.w_index, '0);
        chk1("s4_b2_load", bus.load_en, 1'b1);
        chk1("s4_b2_no_done", bus.block_done, 1'b0);
        chk1("s4_b2_last", bus.block_last, 1'b1);
        chki("s4_b2b_latency", cyc - t0, 65);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        repeat (64) tick();
        chk1("s4_done2", bus.block_done, 1'b1);
        chk1("s4_done2_last", bus.block_last, 1'b1);
        chk1("s4_done2_complete", bus.w_index_complete, 1'b1);
        tick();
        chk1("s4_idle_busy", bus.busy, 1'b0);

        // 5: abort at idx 40, then a full fresh block
        bus.msg_valid = 1'b1;
        tick();
        bus.msg_valid = 1'b0;
        repeat (40) tick();
        chkn("s5_idx40", bus.w_index, IDX_W'(40));
        chk1("s5_expand40", bus.expand_en, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_idle("s5_abort");
        tick();
        chk1("s5_still_no_done", bus.block_done, 1'b0);
        bus.msg_valid = 1'b1;
        tick();
        bus.msg_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chkn("s5_idx", bus.w_index, IDX_W'(i));
            tick();
        end
        chk1("s5_done", bus.block_done, 1'b1);

        // abort in DONE beats a simultaneous new block
        bus.abort     = 1'b1;
        bus.msg_valid = 1'b1;
        bus.msg_last  = 1'b1;
        tick();
        chk_idle("s5_abort_done");
        // abort in IDLE is ignored, block still accepted
        tick();
        bus.abort     = 1'b0;
        bus.msg_valid = 1'b0;
        chk1("s5_idle_abort_busy", bus.busy, 1'b1);
        chk1("s5_idle_abort_load", bus.load_en, 1'b1);
        chkn("s5_idle_abort_idx", bus.w_index, '0);
        chk1("s5_idle_abort_last", bus.block_last, 1'b1);

        // 6: reset mid-block at idx 20
        repeat (20) tick();
        chkn("s6_idx20", bus.w_index, IDX_W'(20));
        chk1("s6_last_before", bus.block_last, 1'b1);
        reset = 1'b0;
        tick();
        chk_idle("s6_reset");
        chk1("s6_block_last", bus.block_last, 1'b0);
        reset = 1'b1;
        tick();
        chk1("s6_after_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
